// File: rtl/gpu_pkg.sv
// Shared rasteriser/GPU definitions: pixel word layout, framebuffer writer
// state encodings and default screen resolution.
package gpu_pkg;

  localparam int PIX_X_MSB   = 59;
  localparam int PIX_X_LSB   = 48;
  localparam int PIX_Y_MSB   = 43;
  localparam int PIX_Y_LSB   = 32;
  localparam int PIX_COL_MSB = 31;
  localparam int PIX_COL_LSB = 0;

  localparam int DEFAULT_H_RES = 640;
  localparam int DEFAULT_V_RES = 480;

  typedef enum logic [1:0] {
    FBW_IDLE  = 2'd0,
    FBW_CALC  = 2'd1,
    FBW_WRITE = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered almost-full flag.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LEVEL   = (AW+1)'(AF_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // almost_full is computed from the next occupancy so it tracks count without lag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      almost_full <= (count_next >= AF_LEVEL);
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Buffers rasteriser pixel words, clips them to the screen and issues one
// 32-bit Avalon-MM framebuffer write per visible pixel.
module pixel_fb_writer
  import gpu_pkg::*;
#(
  parameter int H_RES      = DEFAULT_H_RES,
  parameter int V_RES      = DEFAULT_V_RES,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] pixel_data,
  input  logic        pixel_data_valid,
  output logic        pixel_fifo_full,
  input  logic [31:0] fb_base,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] clipped_count
);

  localparam logic [11:0] X_LIMIT = 12'(H_RES);
  localparam logic [11:0] Y_LIMIT = 12'(V_RES);

  fbw_state_t               state;
  logic [63:0]              fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_pop;
  logic [11:0]              hold_x;
  logic [11:0]              hold_y;
  logic [31:0]              hold_colour;
  logic [23:0]              row_offset;
  logic [31:0]              pixel_index;
  logic [31:0]              wr_address;
  logic                     clip;
  logic                     unused_fifo_bits;

  sync_fifo #(
    .WIDTH     (64),
    .DEPTH     (FIFO_DEPTH),
    .AF_THRESH (FIFO_DEPTH - 2)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_en       (pixel_data_valid),
    .wr_data     (pixel_data),
    .rd_en       (fifo_pop),
    .rd_data     (fifo_rd_data),
    .count       (fifo_count),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (pixel_fifo_full)
  );

  assign unused_fifo_bits = ^{fifo_rd_data[63:60], fifo_rd_data[47:44], fifo_count};

  // The head is consumed in IDLE, or chained straight out of a completing WRITE
  assign fifo_pop = !fifo_empty &&
                    ((state == FBW_IDLE) || (state == FBW_WRITE && !mem_waitrequest));

  always_comb begin
    row_offset  = 24'(hold_y) * 24'(H_RES);
    pixel_index = {8'd0, row_offset} + {20'd0, hold_x};
    wr_address  = fb_base + (pixel_index << 2);
    clip        = (hold_x >= X_LIMIT) || (hold_y >= Y_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= FBW_IDLE;
      hold_x         <= '0;
      hold_y         <= '0;
      hold_colour    <= '0;
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      clipped_count  <= '0;
    end else begin
      busy     <= !fifo_empty || (state != FBW_IDLE);
      overflow <= overflow || (pixel_data_valid && fifo_full && !fifo_pop);
      case (state)
        FBW_IDLE: begin
          if (!fifo_empty) begin
            hold_x      <= fifo_rd_data[PIX_X_MSB:PIX_X_LSB];
            hold_y      <= fifo_rd_data[PIX_Y_MSB:PIX_Y_LSB];
            hold_colour <= fifo_rd_data[PIX_COL_MSB:PIX_COL_LSB];
            state       <= FBW_CALC;
          end
        end
        FBW_CALC: begin
          if (clip) begin
            clipped_count <= clipped_count + 16'd1;
            state         <= FBW_IDLE;
          end else begin
            mem_address    <= wr_address;
            mem_writedata  <= hold_colour;
            mem_byteenable <= 4'hF;
            mem_write      <= 1'b1;
            state          <= FBW_WRITE;
          end
        end
        FBW_WRITE: begin
          if (!mem_waitrequest) begin
            mem_write      <= 1'b0;
            mem_byteenable <= 4'h0;
            if (!fifo_empty) begin
              hold_x      <= fifo_rd_data[PIX_X_MSB:PIX_X_LSB];
              hold_y      <= fifo_rd_data[PIX_Y_MSB:PIX_Y_LSB];
              hold_colour <= fifo_rd_data[PIX_COL_MSB:PIX_COL_LSB];
              state       <= FBW_CALC;
            end else begin
              state <= FBW_IDLE;
            end
          end
        end
        default: state <= FBW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: directed scenarios plus randomized
// pixels checked against a queue-based model of expected framebuffer writes.
module tb_pixel_fb_writer;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] pixel_data = '0;
  logic        pixel_data_valid = 1'b0;
  logic        pixel_fifo_full;
  logic [31:0] fb_base = '0;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic        busy;
  logic        overflow;
  logic [15:0] clipped_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          write_times[$];
  int          exp_clipped = 0;
  int          cycle = 0;
  int          stall_cycles = 0;
  bit          stall_pending = 0;
  logic [31:0] stall_addr;
  logic [31:0] stall_data;
  bit          rand_wait = 0;
  bit          watch_full = 0;
  bit          full_seen = 0;

  pixel_fb_writer #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(16)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .pixel_fifo_full  (pixel_fifo_full),
    .fb_base          (fb_base),
    .mem_address      (mem_address),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_waitrequest  (mem_waitrequest),
    .busy             (busy),
    .overflow         (overflow),
    .clipped_count    (clipped_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: pixel index scaled to bytes, added to the base modulo 2^32
  function automatic logic [31:0] modelAddr(input logic [31:0] base, input int x, input int y);
    longint idx;
    idx = longint'(y) * H_RES + x;
    return 32'(longint'(base) + idx * 4);
  endfunction

  task automatic applyStimulus(input int x, input int y, input logic [31:0] col, input bit accepted);
    logic [11:0] xs;
    logic [11:0] ys;
    xs = 12'(x);
    ys = 12'(y);
    pixel_data = {4'($urandom), xs, 4'($urandom), ys, col};
    pixel_data_valid = 1'b1;
    if (accepted) begin
      if (x >= H_RES || y >= V_RES) exp_clipped++;
      else exp_q.push_back('{modelAddr(fb_base, x, y), col});
    end
    @(posedge clock);
    #1;
    pixel_data_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || mem_write) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clock);
  endtask

  task automatic waitWrite(input int budget);
    int n = 0;
    @(negedge clock);
    while (!mem_write && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) checkOutput("write_timeout", 32'd1, 32'd0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_clipped = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare each completed write to the model, and hold stability during stalls
  always @(negedge clock) begin
    if (watch_full && pixel_fifo_full) full_seen = 1;
    if (reset_n && mem_write) begin
      if (stall_pending) begin
        checkOutput("stall_addr", mem_address, stall_addr);
        checkOutput("stall_data", mem_writedata, stall_data);
      end
      checkOutput("byteenable", {28'd0, mem_byteenable}, 32'hF);
      if (mem_waitrequest) begin
        stall_pending = 1;
        stall_addr = mem_address;
        stall_data = mem_writedata;
        stall_cycles++;
      end else begin
        stall_pending = 0;
        write_times.push_back(cycle);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", mem_address, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          checkOutput("wr_addr", mem_address, e.addr);
          checkOutput("wr_data", mem_writedata, e.data);
        end
      end
    end else begin
      stall_pending = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_wait) mem_waitrequest = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    logic [3:0] seq;
    int guard;

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_address", mem_address, 32'd0);
    checkOutput("rst_mem_writedata", mem_writedata, 32'd0);
    checkOutput("rst_byteenable", {28'd0, mem_byteenable}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_clipped", {16'd0, clipped_count}, 32'd0);
    checkOutput("rst_fifo_full", {31'd0, pixel_fifo_full}, 32'd0);

    $display("[TB] single pixel");
    fb_base = 32'h1000_0000;
    applyStimulus(3, 2, 32'hFF00FF00, 1);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clock);
      seq[i] = mem_write;
    end
    checkOutput("single_timing", {28'd0, seq}, 32'h2);
    waitDrain(50);
    checkOutput("single_busy_idle", {31'd0, busy}, 32'd0);

    $display("[TB] clipping");
    applyStimulus(640, 0, 32'h1111_1111, 1);
    applyStimulus(0, 480, 32'h2222_2222, 1);
    applyStimulus(639, 479, 32'h3333_3333, 1);
    waitDrain(100);
    checkOutput("clip_count", {16'd0, clipped_count}, 32'(exp_clipped));

    $display("[TB] stall");
    mem_waitrequest = 1'b1;
    applyStimulus(10, 20, 32'hAAAA_0001, 1);
    applyStimulus(11, 20, 32'hAAAA_0002, 1);
    waitWrite(50);
    stall_cycles = 0;
    repeat (4) begin
      @(negedge clock);
      checkOutput("stall_hold", {31'd0, mem_write}, 32'd1);
    end
    @(posedge clock);
    #1;
    mem_waitrequest = 1'b0;
    waitDrain(100);
    checkOutput("stall_len", {31'd0, stall_cycles >= 5}, 32'd1);

    $display("[TB] randomized");
    fb_base = $urandom;
    rand_wait = 1;
    for (int i = 0; i < 60; i++) begin
      guard = 0;
      while (pixel_fifo_full && guard < 200) begin
        @(posedge clock);
        #1;
        guard++;
      end
      if (guard >= 200) checkOutput("bp_timeout", 32'd1, 32'd0);
      applyStimulus($urandom_range(0, 700), $urandom_range(0, 520), $urandom, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
    end
    rand_wait = 0;
    @(posedge clock);
    #1;
    mem_waitrequest = 1'b0;
    waitDrain(1000);
    checkOutput("rand_clip_count", {16'd0, clipped_count}, 32'(exp_clipped));
    checkOutput("rand_no_overflow", {31'd0, overflow}, 32'd0);

    $display("[TB] throughput");
    fb_base = 32'h2000_0000;
    write_times.delete();
    full_seen = 0;
    watch_full = 1;
    for (int i = 0; i < 8; i++) applyStimulus(100 + i, 7, 32'hC0DE_0000 + i, 1);
    waitDrain(100);
    watch_full = 0;
    checkOutput("tp_count", 32'(write_times.size()), 32'd8);
    for (int i = 1; i < write_times.size(); i++)
      checkOutput("tp_spacing", 32'(write_times[i] - write_times[i-1]), 32'd2);
    checkOutput("tp_no_full", {31'd0, full_seen}, 32'd0);

    $display("[TB] backpressure and overflow");
    mem_waitrequest = 1'b1;
    applyStimulus(1, 1, 32'hBEEF_0000, 1);
    waitWrite(50);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, 5, 32'hBEEF_0100 + i, i < 16);
      checkOutput("bp_fifo_full", {31'd0, pixel_fifo_full}, {31'd0, (i + 1) >= 14});
      if (i == 15) checkOutput("ovf_before", {31'd0, overflow}, 32'd0);
    end
    checkOutput("ovf_after", {31'd0, overflow}, 32'd1);
    mem_waitrequest = 1'b0;
    waitDrain(200);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    $display("[TB] reset mid-write");
    mem_waitrequest = 1'b1;
    applyStimulus(5, 5, 32'h5555_0000, 1);
    applyStimulus(6, 5, 32'h5555_0001, 1);
    waitWrite(50);
    doReset();
    @(negedge clock);
    checkOutput("mid_rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("mid_rst_clipped", {16'd0, clipped_count}, 32'd0);
    mem_waitrequest = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(7, 9, 32'h7777_0009, 1);
    waitDrain(50);
    checkOutput("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
